// File: rtl/cmd_tx.sv
// Readback responder: snapshots one addressed register per request
// and streams it out as an 8-byte reply frame.
module cmd_tx #(
  parameter logic [7:0]  SOF_BYTE = 8'hA5,
  parameter logic [31:0] VERSION  = 32'h2025_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [7:0]  rd_addr,
  output logic        rd_ready,
  output logic        rd_drop,
  input  logic [1:0]  ChannelSel,
  input  logic [31:0] DataNum,
  input  logic [31:0] ADC_Speed_Set,
  input  logic        StreamMode,
  input  logic [31:0] status_word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic [15:0] frame_cnt
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  stat_q, stat_d;
  logic [31:0] data_q, data_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        drop_q, drop_d;

  logic [7:0]  lk_stat;
  logic [31:0] lk_data;
  logic [7:0]  chk;
  logic        hs;

  // Live register view for the address being requested
  always_comb begin
    lk_stat = 8'h00;
    lk_data = 32'hFFFF_FFFF;
    case (rd_addr)
      8'h01:   lk_data = {30'd0, ChannelSel};
      8'h02:   lk_data = DataNum;
      8'h03:   lk_data = ADC_Speed_Set;
      8'h04:   lk_data = {31'd0, StreamMode};
      8'h05:   lk_data = status_word;
      8'h10:   lk_data = VERSION;
      default: lk_stat = 8'h01;
    endcase
  end

  assign chk = addr_q ^ stat_q ^ data_q[31:24] ^ data_q[23:16]
             ^ data_q[15:8] ^ data_q[7:0];

  assign rd_ready  = (state_q == IDLE);
  assign tx_valid  = (state_q == SEND);
  assign tx_last   = tx_valid && (idx_q == 3'd7);
  assign hs        = tx_valid && tx_ready;
  assign rd_drop   = drop_q;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    tx_data = 8'h00;
    if (tx_valid) begin
      unique case (idx_q)
        3'd0: tx_data = SOF_BYTE;
        3'd1: tx_data = addr_q;
        3'd2: tx_data = stat_q;
        3'd3: tx_data = data_q[31:24];
        3'd4: tx_data = data_q[23:16];
        3'd5: tx_data = data_q[15:8];
        3'd6: tx_data = data_q[7:0];
        3'd7: tx_data = chk;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    stat_d      = stat_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    drop_d      = rd_req && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d  = rd_addr;
          stat_d  = lk_stat;
          data_d  = lk_data;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d     = IDLE;
            idx_d       = 3'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      addr_q      <= 8'h00;
      stat_q      <= 8'h00;
      data_q      <= 32'h0;
      frame_cnt_q <= 16'h0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      stat_q      <= stat_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_cmd_tx.sv
// Bench for cmd_tx: fixed reply vectors, randomized frames against a
// frame-level model, backpressure, drop, reset and counter wrap.
module tb_cmd_tx;

  logic        clk = 0;
  logic        reset_n;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_ready;
  logic        rd_drop;
  logic [1:0]  ChannelSel;
  logic [31:0] DataNum;
  logic [31:0] ADC_Speed_Set;
  logic        StreamMode;
  logic [31:0] status_word;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  logic [15:0] exp_cnt = 0;

  cmd_tx dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_drop(rd_drop),
    .ChannelSel(ChannelSel), .DataNum(DataNum),
    .ADC_Speed_Set(ADC_Speed_Set), .StreamMode(StreamMode),
    .status_word(status_word),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rd_drop === 1'b1) drop_cnt++;

  typedef struct {
    logic [7:0]  addr;
    logic [1:0]  cs;
    logic [31:0] dn;
    logic [31:0] adc;
    logic        sm;
    logic [31:0] st;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reply frame derived straight from the address map and framing rules
  function automatic logic [63:0] model(input logic [7:0] a);
    logic [31:0] d;
    logic [7:0]  s;
    logic [7:0]  by[8];
    logic [63:0] r;
    s = 8'h00;
    if (a == 8'h01)      d = 32'(ChannelSel);
    else if (a == 8'h02) d = DataNum;
    else if (a == 8'h03) d = ADC_Speed_Set;
    else if (a == 8'h04) d = 32'(StreamMode);
    else if (a == 8'h05) d = status_word;
    else if (a == 8'h10) d = 32'h2025_0001;
    else begin d = 32'hFFFF_FFFF; s = 8'h01; end
    by[0] = 8'hA5; by[1] = a; by[2] = s;
    for (int i = 0; i < 4; i++) by[3+i] = d[31-8*i -: 8];
    by[7] = 8'h00;
    for (int i = 1; i < 7; i++) by[7] = by[7] ^ by[i];
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], by[i]};
    return r;
  endfunction

  task automatic send_req(input logic [7:0] a);
    rd_addr = a;
    rd_req  = 1;
    chk("rd_ready", rd_ready, 1);
    @(negedge clk);
    rd_req = 0;
    #1;
    chk("latency_valid", tx_valid, 1);
    chk("latency_sof", tx_data, 8'hA5);
  endtask

  task automatic collect(input int duty, input int maxb, input int drop_at,
                         output logic [7:0] b[$]);
    logic [7:0] prev;
    logic stall, pulsed;
    int n;
    b = {}; stall = 0; pulsed = 0; n = 0; prev = 0;
    while (b.size() < maxb && n < 400) begin
      tx_ready = ($urandom_range(0, 99) < duty);
      rd_req = 0;
      if (b.size() == drop_at && !pulsed) begin
        rd_req = 1; rd_addr = 8'h05; pulsed = 1;
      end
      #1;
      chk("valid_hold", tx_valid, 1);
      if (stall) chk("stall_stable", tx_data, prev);
      if (tx_valid && tx_ready) begin
        chk("last_flag", tx_last, b.size() == 7);
        b.push_back(tx_data);
      end
      stall = tx_valid && !tx_ready;
      prev = tx_data;
      @(negedge clk);
      n++;
    end
    rd_req = 0;
    tx_ready = 0;
    if (n >= 400) begin
      errors++;
      $display("FAIL collect_timeout: got %0d bytes required %0d", b.size(), maxb);
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [63:0] exp,
                           input int duty, input int drop_at, input string nm);
    logic [7:0] b[$];
    logic [63:0] v;
    send_req(a);
    collect(duty, 8, drop_at, b);
    v = '0;
    foreach (b[i]) v = {v[55:0], b[i]};
    chk({nm, "_nbytes"}, 64'(b.size()), 8);
    chk({nm, "_bytes"}, v, exp);
    exp_cnt++;
    #1;
    chk({nm, "_idle"}, tx_valid, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, exp_cnt);
  endtask

  task automatic load(input vec_t v);
    ChannelSel = v.cs; DataNum = v.dn; ADC_Speed_Set = v.adc;
    StreamMode = v.sm; status_word = v.st;
  endtask

  vec_t vt[8];
  logic [7:0] alist[9];

  initial begin
    logic [7:0] b[$];
    int d0;
    vt[0] = '{8'h02, 2'd0, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 64'hA5_02_00_12_34_56_78_0A};
    vt[1] = '{8'h07, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0, 64'hA5_07_01_FF_FF_FF_FF_06};
    vt[2] = '{8'h10, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0, 64'hA5_10_00_20_25_00_01_14};
    vt[3] = '{8'h01, 2'd2, 32'h0, 32'h0, 1'b0, 32'h0, 64'hA5_01_00_00_00_00_02_03};
    vt[4] = '{8'h04, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0, 64'hA5_04_00_00_00_00_01_05};
    vt[5] = '{8'h05, 2'd0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 64'hA5_05_00_DE_AD_BE_EF_27};
    vt[6] = '{8'h03, 2'd0, 32'h0, 32'h32, 1'b0, 32'h0, 64'hA5_03_00_00_00_00_32_31};
    vt[7] = '{8'h00, 2'd3, 32'h5, 32'h6, 1'b1, 32'h7, 64'hA5_00_01_FF_FF_FF_FF_01};
    alist = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h06, 8'hFF};

    reset_n = 0; rd_req = 0; rd_addr = 0; tx_ready = 0;
    load(vt[0]);
    #12;
    chk("rst_valid", tx_valid, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_drop", rd_drop, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_ready", rd_ready, 1);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      load(vt[i]);
      run_frame(vt[i].addr, vt[i].exp, 100, -1, $sformatf("vec%0d", i));
    end

    load(vt[0]);
    run_frame(8'h02, vt[0].exp, 30, -1, "backpressure");

    // Snapshot: register changes after acceptance, plus a dropped request
    load(vt[6]);
    d0 = drop_cnt;
    send_req(8'h03);
    ADC_Speed_Set = 32'h99;
    collect(60, 8, 3, b);
    exp_cnt++;
    begin
      logic [63:0] v;
      v = '0;
      foreach (b[i]) v = {v[55:0], b[i]};
      chk("snap_bytes", v, vt[6].exp);
    end
    for (int i = 0; i < 5; i++) begin
      #1 chk("snap_no_second", tx_valid, 0);
      @(negedge clk);
    end
    chk("snap_drop_once", 64'(drop_cnt - d0), 1);
    chk("snap_cnt", frame_cnt, exp_cnt);

    // Request coinciding with the final handshake is dropped
    load(vt[3]);
    d0 = drop_cnt;
    run_frame(8'h01, vt[3].exp, 100, 7, "last_drop");
    @(negedge clk);
    #1 chk("last_drop_idle", tx_valid, 0);
    chk("last_drop_once", 64'(drop_cnt - d0), 1);

    // Reset mid-frame after three bytes
    load(vt[5]);
    send_req(8'h05);
    collect(100, 3, -1, b);
    chk("pre_rst_bytes", 64'(b.size()), 3);
    reset_n = 0;
    #1;
    chk("midrst_valid", tx_valid, 0);
    chk("midrst_cnt", frame_cnt, 0);
    chk("midrst_data", tx_data, 0);
    exp_cnt = 0;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    load(vt[3]);
    run_frame(8'h01, vt[3].exp, 100, -1, "after_rst");

    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      a = (i % 4 == 3) ? 8'($urandom) : alist[$urandom_range(0, 8)];
      ChannelSel = 2'($urandom);
      DataNum = $urandom;
      ADC_Speed_Set = $urandom;
      StreamMode = 1'($urandom);
      status_word = $urandom;
      run_frame(a, model(a), $urandom_range(30, 100), -1, "rand");
    end

    // Counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    #1;
    chk("wrap_preload", frame_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    load(vt[2]);
    run_frame(8'h10, vt[2].exp, 100, -1, "wrap");
    chk("wrap_zero", frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
